alu_pipe: RTL and testbench

//  Pipelined, parametrised successor of the 32-bit ALU-with-zero.
//  Two register stages with valid/ready handshakes on both sides, so a

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_pipe_if.sv | 28 ++
 rtl/alu_core.sv | 44 ++++
 rtl/alu_pipe.sv | 73 +++++++
 tb/tb_alu_pipe.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and flag-vector bit positions shared by the ALU pipeline
package alu_pkg;
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_ANDN = 3'd4;
    localparam logic [2:0] OP_ORN  = 3'd5;
    localparam logic [2:0] OP_SLL  = 3'd6;
    localparam logic [2:0] OP_SLT  = 3'd7;
    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/response bundle of the pipelined ALU
//   request : in_valid, in_ready, a, b, sel, in_tag
//   response: out_valid, out_ready, y, z_flag, n_flag, c_flag, v_flag, out_tag
//   master drives requests and out_ready; slave is the ALU side
interface alu_pipe_if #(parameter int N = 32, parameter int TAG_W = 4);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [2:0]       sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     y;
    logic             z_flag;
    logic             n_flag;
    logic             c_flag;
    logic             v_flag;
    logic [TAG_W-1:0] out_tag;
    modport master (
        output in_valid, a, b, sel, in_tag, out_ready,
        input  in_ready, out_valid, y, z_flag, n_flag, c_flag, v_flag, out_tag
    );
    modport slave (
        input  in_valid, a, b, sel, in_tag, out_ready,
        output in_ready, out_valid, y, z_flag, n_flag, c_flag, v_flag, out_tag
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational N-bit ALU producing result and Z/N/C/V flags
//   a, b : operands      sel : opcode (alu_pkg OP_*)
//   y    : result        z, n, c, v : zero, negative, carry/no-borrow, signed overflow
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   sel,
    output logic [N-1:0] y,
    output logic         z,
    output logic         n,
    output logic         c,
    output logic         v
);
    localparam int SW = $clog2(N);
    logic [N:0]   sum;
    logic [N:0]   dif;
    logic         v_add;
    logic         v_sub;
    logic [N-1:0] r [8];
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        dif   = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        v_add = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
        v_sub = (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
        r[OP_AND]  = a & b;
        r[OP_OR]   = a | b;
        r[OP_ADD]  = sum[N-1:0];
        r[OP_SUB]  = dif[N-1:0];
        r[OP_ANDN] = a & ~b;
        r[OP_ORN]  = a | ~b;
        r[OP_SLL]  = a << b[SW-1:0];
        // signed less-than from the subtractor: sign of a-b corrected by overflow
        r[OP_SLT]  = {{(N-1){1'b0}}, dif[N-1] ^ v_sub};
        y = r[sel];
        z = ~|y;
        n = y[N-1];
        c = (sel == OP_ADD) ? sum[N] : (sel == OP_SUB) ? dif[N] : 1'b0;
        v = (sel == OP_ADD) ? v_add : (sel == OP_SUB) ? v_sub : 1'b0;
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU with registered flags and pass-through tag
//   clk, rst : clock and asynchronous active-high reset
//   bus      : alu_pipe_if slave; stage 1 holds a/b/sel/tag, stage 2 holds y/flags/tag
module alu_pipe
    import alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 4
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d, adv1, adv2;
    logic [N-1:0]     a_q, a_d, b_q, b_d, y_q, y_d, core_y;
    logic [2:0]       sel_q, sel_d;
    logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
    logic [3:0]       flg_q, flg_d, flg_new;
    logic             core_z, core_n, core_c, core_v;
    alu_core #(.N(N)) u_core (
        .a(a_q), .b(b_q), .sel(sel_q),
        .y(core_y), .z(core_z), .n(core_n), .c(core_c), .v(core_v)
    );
    always_comb begin
        adv2 = !s2_v_q || bus.out_ready;
        adv1 = !s1_v_q || adv2;
        s1_v_d = adv1 ? bus.in_valid : s1_v_q;
        a_d    = (adv1 && bus.in_valid) ? bus.a : a_q;
        b_d    = (adv1 && bus.in_valid) ? bus.b : b_q;
        sel_d  = (adv1 && bus.in_valid) ? bus.sel : sel_q;
        tag1_d = (adv1 && bus.in_valid) ? bus.in_tag : tag1_q;
        flg_new = '0;
        flg_new[FLG_Z] = core_z;
        flg_new[FLG_N] = core_n;
        flg_new[FLG_C] = core_c;
        flg_new[FLG_V] = core_v;
        s2_v_d = adv2 ? s1_v_q : s2_v_q;
        y_d    = (adv2 && s1_v_q) ? core_y : y_q;
        flg_d  = (adv2 && s1_v_q) ? flg_new : flg_q;
        tag2_d = (adv2 && s1_v_q) ? tag1_q : tag2_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sel_q  <= '0;
            tag1_q <= '0;
            s2_v_q <= 1'b0;
            y_q    <= '0;
            flg_q  <= '0;
            tag2_q <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sel_q  <= sel_d;
            tag1_q <= tag1_d;
            s2_v_q <= s2_v_d;
            y_q    <= y_d;
            flg_q  <= flg_d;
            tag2_q <= tag2_d;
        end
    end
    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_v_q;
    assign bus.y         = y_q;
    assign bus.z_flag    = flg_q[FLG_Z];
    assign bus.n_flag    = flg_q[FLG_N];
    assign bus.c_flag    = flg_q[FLG_C];
    assign bus.v_flag    = flg_q[FLG_V];
    assign bus.out_tag   = tag2_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against an arithmetic reference model
module tb_alu_pipe;
    import alu_pkg::*;
    typedef struct packed {
        logic [31:0] y;
        logic [3:0]  f;
        logic [3:0]  tag;
    } res_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    alu_pipe_if #(.N(32), .TAG_W(4)) bus ();
    alu_pipe #(.N(32), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    res_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       acc = 1'b0;
    logic [3:0] tag_n = 4'd0;
    res_t       held;
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input logic [3:0] tag);
        longint sa, sb, r;
        res_t   m;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        m = '0;
        m.tag = tag;
        case (op)
            OP_AND:  m.y = a & b;
            OP_OR:   m.y = a | b;
            OP_ADD: begin
                r = longint'(a) + longint'(b);
                m.y = r[31:0];
                m.f[FLG_C] = r > 64'sd4294967295;
                r = sa + sb;
                m.f[FLG_V] = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            OP_SUB: begin
                m.y = a - b;
                m.f[FLG_C] = a >= b;
                r = sa - sb;
                m.f[FLG_V] = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            OP_ANDN: m.y = a & ~b;
            OP_ORN:  m.y = a | ~b;
            OP_SLL:  m.y = a << (b % 32);
            default: m.y = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        m.f[FLG_Z] = (m.y == 32'd0);
        m.f[FLG_N] = m.y[31];
        return m;
    endfunction
    function automatic logic [3:0] obs_f();
        logic [3:0] f;
        f = '0;
        f[FLG_Z] = bus.z_flag;
        f[FLG_N] = bus.n_flag;
        f[FLG_C] = bus.c_flag;
        f[FLG_V] = bus.v_flag;
        return f;
    endfunction
    function automatic res_t obs();
        return '{bus.y, obs_f(), bus.out_tag};
    endfunction
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask
    // one clock: score transfers at the negedge, then return #1 after the next posedge
    task automatic tick();
        res_t e;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            chk("result_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("y", bus.y, e.y);
                chk("flags", obs_f(), e.f);
                chk("tag", bus.out_tag, e.tag);
            end
        end
        if (acc) exp_q.push_back(model(bus.a, bus.b, bus.sel, bus.in_tag));
        @(posedge clk);
        #1;
    endtask
    task automatic new_op();
        bus.a = $urandom;
        bus.b = $urandom;
        bus.sel = 3'($urandom_range(0, 7));
        bus.in_tag = tag_n;
        tag_n = tag_n + 4'd1;
    endtask
    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [3:0] tag);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.sel = op;
        bus.in_tag = tag;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) tick();
        chk("accept", acc, 1);
        bus.in_valid = 1'b0;
    endtask
    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
        chk("drain", exp_q.size(), 0);
    endtask
    // single op into an empty pipe: result must appear exactly two edges after transfer
    task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic [3:0] tag,
                            input logic [31:0] ey, input logic [3:0] ef);
        drive(a, b, op, tag);
        chk({nm, "_early"}, bus.out_valid, 0);
        tick();
        chk({nm, "_valid"}, bus.out_valid, 1);
        chk({nm, "_y"}, bus.y, ey);
        chk({nm, "_flags"}, obs_f(), ef);
        chk({nm, "_tag"}, bus.out_tag, tag);
        tick();
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.sel = '0;
        bus.in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_flags", obs_f(), 0);
        chk("rst_tag", bus.out_tag, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        // flags packed as {Z,N,C,V}
        directed("add_wrap", 32'hFFFF_FFFF, 32'h1, OP_ADD, 4'd3, 32'h0, 4'b1010);
        directed("sub_ovf", 32'h8000_0000, 32'h1, OP_SUB, 4'd4, 32'h7FFF_FFFF, 4'b0011);
        directed("sub_borrow", 32'h1, 32'h2, OP_SUB, 4'd5, 32'hFFFF_FFFF, 4'b0100);
        directed("slt_neg", 32'hFFFF_FFFF, 32'h1, OP_SLT, 4'd6, 32'h1, 4'b0000);
        directed("slt_ovf", 32'h7FFF_FFFF, 32'h8000_0000, OP_SLT, 4'd7, 32'h0, 4'b1000);
        directed("sll", 32'h1, 32'h25, OP_SLL, 4'd8, 32'h20, 4'b0000);
        directed("orn", 32'h0, 32'h0, OP_ORN, 4'd9, 32'hFFFF_FFFF, 4'b0100);
        directed("andn", 32'hF0F0_F0F0, 32'hF000_0000, OP_ANDN, 4'd10, 32'h00F0_F0F0, 4'b0000);
        // back-to-back: eight ops, one per cycle, all drained two cycles after the last
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.a = $urandom;
            bus.b = $urandom;
            bus.sel = 3'(i);
            bus.in_tag = 4'(i);
            tick();
            chk("b2b_accept", acc, 1);
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("b2b_done", exp_q.size(), 0);
        // backpressure: two ops absorbed, then in_ready drops and outputs hold
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        new_op();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_accept", acc, i < 2);
            if (acc) new_op();
            if (i == 2) held = obs();
        end
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_hold", obs(), held);
        bus.out_ready = 1'b1;
        tick();
        chk("full_push_pop", acc, 1);
        chk("still_full", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        drain();
        // random traffic with random backpressure, honouring the hold-until-transfer rule
        acc = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (!bus.in_valid || acc) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                new_op();
            end
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && bus.in_valid && !acc; i++) tick();
        bus.in_valid = 1'b0;
        drain();
        // reset in the middle of a stall
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        new_op();
        tick();
        new_op();
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("stall_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_y", bus.y, 0);
        chk("midrst_flags", obs_f(), 0);
        chk("midrst_tag", bus.out_tag, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        directed("post_rst", 32'd100, 32'd23, OP_ADD, 4'd9, 32'd123, 4'b0000);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
